// File: rtl/cache_refill_ctrl_pkg.sv
// rtl/cache_refill_ctrl_pkg.sv - shared types, geometry constants and helpers for the refill controller
package cache_ctrl_pkg;

    localparam int NUM_WAYS   = 4;
    localparam int NUM_SETS   = 128;
    localparam int LINE_WORDS = 4;

    localparam int WAY_W    = $clog2(NUM_WAYS);
    localparam int SET_W    = $clog2(NUM_SETS);
    localparam int BEAT_W   = $clog2(LINE_WORDS);
    localparam int WORD_LSB = 2;
    localparam int SET_LSB  = WORD_LSB + BEAT_W;
    localparam int TAG_LSB  = SET_LSB + SET_W;
    localparam int TAG_W    = 32 - TAG_LSB;
    localparam int CACHE_AW = SET_W + BEAT_W;
    localparam int TAG_AW   = SET_W + 1;

    typedef enum logic [2:0] {
        RST_WAIT,
        FLUSH,
        IDLE,
        INVAL,
        REQ,
        FILL,
        TAG,
        DONE
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [30-TAG_W:0] rsvd;
        logic [TAG_W-1:0]  tag;
    } tag_entry_t;

    // Active-low one-hot write enable selecting a single way
    function automatic logic [NUM_WAYS-1:0] way_web(input logic [WAY_W-1:0] way);
        way_web = ~(NUM_WAYS'(1) << way);
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// rtl/cache_refill_ctrl_if.sv - miss, memory and SRAM write signals of the refill controller
interface cache_refill_ctrl_if;
    import cache_ctrl_pkg::*;

    logic                miss_vld_i;
    logic                miss_rdy_o;
    logic [31:0]         miss_addr_i;
    logic                flush_i;
    logic                busy_o;
    logic                done_o;
    logic [WAY_W-1:0]    done_way_o;
    logic                mem_req_vld_o;
    logic                mem_req_rdy_i;
    logic [31:0]         mem_req_addr_o;
    logic                mem_rsp_vld_i;
    logic                mem_rsp_rdy_o;
    logic [31:0]         mem_rsp_dat_i;
    logic [NUM_WAYS-1:0] cache_web_o;
    logic [CACHE_AW-1:0] cache_addr_o;
    logic [31:0]         cache_wdat_o;
    logic [NUM_WAYS-1:0] tag_web_o;
    logic [TAG_AW-1:0]   tag_addr_o;
    logic [31:0]         tag_wdat_o;

    modport master (
        input  miss_vld_i, miss_addr_i, flush_i, mem_req_rdy_i, mem_rsp_vld_i, mem_rsp_dat_i,
        output miss_rdy_o, busy_o, done_o, done_way_o, mem_req_vld_o, mem_req_addr_o,
               mem_rsp_rdy_o, cache_web_o, cache_addr_o, cache_wdat_o,
               tag_web_o, tag_addr_o, tag_wdat_o
    );

    modport slave (
        output miss_vld_i, miss_addr_i, flush_i, mem_req_rdy_i, mem_rsp_vld_i, mem_rsp_dat_i,
        input  miss_rdy_o, busy_o, done_o, done_way_o, mem_req_vld_o, mem_req_addr_o,
               mem_rsp_rdy_o, cache_web_o, cache_addr_o, cache_wdat_o,
               tag_web_o, tag_addr_o, tag_wdat_o
    );

endinterface

// File: rtl/cache_refill_ctrl_victim_sel.sv
// rtl/cache_refill_ctrl_victim_sel.sv - round-robin victim way pointer
module cache_victim_sel
    import cache_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [WAY_W-1:0] way
);

    // Step to the next way after each completed refill; wraps naturally since NUM_WAYS is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            way <= '0;
        end else if (advance) begin
            way <= way + WAY_W'(1);
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - line refill and tag flush sequencer for the 4-way cache
module cache_refill_ctrl
    import cache_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    cache_refill_ctrl_if.master  bus
);

    state_t            state;
    logic [SET_W-1:0]  cnt;
    logic [BEAT_W-1:0] beat;
    logic [SET_W-1:0]  set_q;
    logic [TAG_W-1:0]  tag_q;
    logic [WAY_W-1:0]  way_q;
    logic [WAY_W-1:0]  victim;
    logic              miss_rdy_q;
    logic              beat_fire;
    tag_entry_t        valid_entry;

    cache_victim_sel u_victim (
        .clk     (clk),
        .reset   (reset),
        .advance (state == DONE),
        .way     (victim)
    );

    // A pending flush request masks miss acceptance in the same IDLE cycle
    assign bus.miss_rdy_o = miss_rdy_q & ~bus.flush_i;

    // Data beats are written straight through in the cycle they are accepted
    assign beat_fire        = (state == FILL) & bus.mem_rsp_vld_i & bus.mem_rsp_rdy_o;
    assign bus.cache_web_o  = beat_fire ? way_web(way_q) : '1;
    assign bus.cache_addr_o = beat_fire ? {set_q, beat} : '0;
    assign bus.cache_wdat_o = beat_fire ? bus.mem_rsp_dat_i : '0;

    // Final tag entry: valid bit plus the latched tag, reserved bits zero
    always_comb begin
        valid_entry       = '0;
        valid_entry.valid = 1'b1;
        valid_entry.tag   = tag_q;
    end

    // Main sequencer; every registered output is set on the transition into the state that owns it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= RST_WAIT;
            cnt                <= '0;
            beat               <= '0;
            set_q              <= '0;
            tag_q              <= '0;
            way_q              <= '0;
            miss_rdy_q         <= 1'b0;
            bus.busy_o         <= 1'b1;
            bus.done_o         <= 1'b0;
            bus.done_way_o     <= '0;
            bus.mem_req_vld_o  <= 1'b0;
            bus.mem_req_addr_o <= '0;
            bus.mem_rsp_rdy_o  <= 1'b0;
            bus.tag_web_o      <= '1;
            bus.tag_addr_o     <= '0;
            bus.tag_wdat_o     <= '0;
        end else begin
            bus.done_o     <= 1'b0;
            bus.tag_web_o  <= '1;
            bus.tag_addr_o <= '0;
            bus.tag_wdat_o <= '0;
            case (state)
                RST_WAIT: begin
                    state         <= FLUSH;
                    cnt           <= '0;
                    bus.tag_web_o <= '0;
                end
                FLUSH: begin
                    if (cnt == SET_W'(NUM_SETS - 1)) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        bus.busy_o <= 1'b0;
                        miss_rdy_q <= 1'b1;
                    end else begin
                        cnt            <= cnt + SET_W'(1);
                        bus.tag_web_o  <= '0;
                        bus.tag_addr_o <= {1'b0, cnt + SET_W'(1)};
                    end
                end
                IDLE: begin
                    if (bus.flush_i) begin
                        state         <= FLUSH;
                        cnt           <= '0;
                        miss_rdy_q    <= 1'b0;
                        bus.busy_o    <= 1'b1;
                        bus.tag_web_o <= '0;
                    end else if (bus.miss_vld_i && bus.miss_rdy_o) begin
                        state          <= INVAL;
                        set_q          <= bus.miss_addr_i[SET_LSB +: SET_W];
                        tag_q          <= bus.miss_addr_i[TAG_LSB +: TAG_W];
                        way_q          <= victim;
                        miss_rdy_q     <= 1'b0;
                        bus.busy_o     <= 1'b1;
                        bus.tag_web_o  <= way_web(victim);
                        bus.tag_addr_o <= {1'b0, bus.miss_addr_i[SET_LSB +: SET_W]};
                    end
                end
                INVAL: begin
                    state              <= REQ;
                    bus.mem_req_vld_o  <= 1'b1;
                    bus.mem_req_addr_o <= {tag_q, set_q, {SET_LSB{1'b0}}};
                end
                REQ: begin
                    if (bus.mem_req_rdy_i) begin
                        state              <= FILL;
                        beat               <= '0;
                        bus.mem_req_vld_o  <= 1'b0;
                        bus.mem_req_addr_o <= '0;
                        bus.mem_rsp_rdy_o  <= 1'b1;
                    end
                end
                FILL: begin
                    if (beat_fire) begin
                        beat <= beat + BEAT_W'(1);
                        if (beat == BEAT_W'(LINE_WORDS - 1)) begin
                            state             <= TAG;
                            bus.mem_rsp_rdy_o <= 1'b0;
                            bus.tag_web_o     <= way_web(way_q);
                            bus.tag_addr_o    <= {1'b0, set_q};
                            bus.tag_wdat_o    <= valid_entry;
                        end
                    end
                end
                TAG: begin
                    state          <= DONE;
                    bus.done_o     <= 1'b1;
                    bus.done_way_o <= way_q;
                end
                DONE: begin
                    state          <= IDLE;
                    bus.busy_o     <= 1'b0;
                    bus.done_way_o <= '0;
                    miss_rdy_q     <= 1'b1;
                end
                default: begin
                    state <= RST_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - self-checking bench for cache_refill_ctrl with a write-event reference model
module tb_cache_refill_ctrl;
    import cache_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cache_refill_ctrl_if bus();

    cache_refill_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  web;
        logic [8:0]  addr;
        logic [31:0] dat;
    } wr_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_victim = 0;
    wr_t tag_eq[$];
    wr_t cw_eq[$];
    int done_q[$];
    int done_log[$];
    logic [31:0] exp_req_addr = '0;

    int          mon_nlow;
    wr_t         mon_e;
    int          done_cyc = 0;
    int          strobe_cnt = 0;
    logic [7:0]  last_inval_addr = '0;
    logic [7:0]  last_tag_addr = '0;
    logic [31:0] last_tag_wdat = '0;
    logic [8:0]  last_cache_addr = '0;
    logic [31:0] last_cache_wdat = '0;
    logic [31:0] seen_req_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bounded wait expired, required DUT event never seen", name);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    function automatic wr_t mk(input logic [3:0] web, input logic [8:0] a, input logic [31:0] d);
        wr_t r;
        r.web  = web;
        r.addr = a;
        r.dat  = d;
        return r;
    endfunction

    task automatic push_flush();
        for (int i = 0; i < 128; i++) tag_eq.push_back(mk(4'h0, 9'(i), 32'h0));
    endtask

    // Compare every observed SRAM write, completion and request against the expected event queues
    always @(negedge clk) begin
        if (!reset) begin
            mon_nlow = 0;
            for (int w = 0; w < 4; w++) mon_nlow += int'(!bus.cache_web_o[w]) + int'(!bus.tag_web_o[w]);
            if (bus.tag_web_o != 4'h0) chk("one_we_low", 32'(mon_nlow <= 1), 32'd1);
            if (bus.tag_web_o != 4'hF) begin
                if (tag_eq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tag_write: unexpected write web=%b addr=0x%0h, required none", bus.tag_web_o, bus.tag_addr_o);
                end else begin
                    mon_e = tag_eq.pop_front();
                    chk("tag_web", 32'(bus.tag_web_o), 32'(mon_e.web));
                    chk("tag_addr", 32'(bus.tag_addr_o), 32'(mon_e.addr));
                    chk("tag_wdat", bus.tag_wdat_o, mon_e.dat);
                end
                if (bus.tag_web_o != 4'h0 && bus.tag_wdat_o == 32'h0) last_inval_addr = bus.tag_addr_o;
                last_tag_addr = bus.tag_addr_o;
                last_tag_wdat = bus.tag_wdat_o;
            end
            if (bus.cache_web_o != 4'hF) begin
                strobe_cnt++;
                chk("strobe_on_beat", 32'(bus.mem_rsp_vld_i & bus.mem_rsp_rdy_o), 32'd1);
                if (cw_eq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cache_write: unexpected write web=%b addr=0x%0h, required none", bus.cache_web_o, bus.cache_addr_o);
                end else begin
                    mon_e = cw_eq.pop_front();
                    chk("cache_web", 32'(bus.cache_web_o), 32'(mon_e.web));
                    chk("cache_addr", 32'(bus.cache_addr_o), 32'(mon_e.addr));
                    chk("cache_wdat", bus.cache_wdat_o, mon_e.dat);
                end
                last_cache_addr = bus.cache_addr_o;
                last_cache_wdat = bus.cache_wdat_o;
            end
            if (bus.done_o) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done: unexpected done_o way=%0d, required none", bus.done_way_o);
                end else begin
                    chk("done_way", 32'(bus.done_way_o), 32'(done_q.pop_front()));
                end
                done_log.push_back(int'(bus.done_way_o));
                done_cyc = cyc;
            end
            if (bus.mem_req_vld_o) begin
                chk("req_addr", bus.mem_req_addr_o, exp_req_addr);
                seen_req_addr = bus.mem_req_addr_o;
            end
        end
    end

    task automatic do_reset(input bit sync);
        if (sync) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        tag_eq.delete();
        cw_eq.delete();
        done_q.delete();
        model_victim = 0;
        #1;
        chk("rst_miss_rdy", 32'(bus.miss_rdy_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd1);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_done_way", 32'(bus.done_way_o), 32'd0);
        chk("rst_req_vld", 32'(bus.mem_req_vld_o), 32'd0);
        chk("rst_req_addr", bus.mem_req_addr_o, 32'd0);
        chk("rst_rsp_rdy", 32'(bus.mem_rsp_rdy_o), 32'd0);
        chk("rst_cache_web", 32'(bus.cache_web_o), 32'hF);
        chk("rst_cache_addr", 32'(bus.cache_addr_o), 32'd0);
        chk("rst_cache_wdat", bus.cache_wdat_o, 32'd0);
        chk("rst_tag_web", 32'(bus.tag_web_o), 32'hF);
        chk("rst_tag_addr", 32'(bus.tag_addr_o), 32'd0);
        chk("rst_tag_wdat", bus.tag_wdat_o, 32'd0);
        bus.miss_vld_i    = 1'b0;
        bus.flush_i       = 1'b0;
        bus.mem_req_rdy_i = 1'b0;
        bus.mem_rsp_vld_i = 1'b0;
        bus.mem_rsp_dat_i = '0;
        repeat (2) @(posedge clk);
        push_flush();
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_wait_tag_web", 32'(bus.tag_web_o), 32'hF);
        chk("rst_wait_busy", 32'(bus.busy_o), 32'd1);
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            chk("flush_busy", 32'(bus.busy_o), 32'd1);
            chk("flush_rdy", 32'(bus.miss_rdy_o), 32'd0);
        end
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy_o), 32'd0);
        chk("idle_rdy", 32'(bus.miss_rdy_o), 32'd1);
        chk("flush_writes_left", 32'(tag_eq.size()), 32'd0);
    endtask

    task automatic do_flush();
        int n;
        push_flush();
        @(posedge clk); #1;
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (!bus.busy_o) break;
            n++;
            if (n > 200) begin timeout_fail("flush_end"); return; end
        end
        chk("flush_len", 32'(n), 32'd128);
        chk("flush_writes_left", 32'(tag_eq.size()), 32'd0);
    endtask

    task automatic do_miss(input logic [31:0] addr, input int stall, input logic [3:0] bubble,
                           input int abort, input logic [31:0] base, output int acc, output int waited);
        logic [31:0] data [4];
        logic [3:0]  web;
        logic [6:0]  set;
        logic [20:0] tg;
        int          w;
        int          n;
        set = 7'((addr >> 4) % 128);
        tg  = 21'(addr >> 11);
        w   = model_victim;
        web = 4'hF ^ (4'h1 << w);
        for (int i = 0; i < 4; i++) data[i] = (base != 0) ? base + 32'(i) : $urandom;
        tag_eq.push_back(mk(web, {2'b00, set}, 32'h0));
        for (int i = 0; i < 4; i++) cw_eq.push_back(mk(web, {set, 2'(i)}, data[i]));
        tag_eq.push_back(mk(web, {2'b00, set}, 32'h8000_0000 | 32'(tg)));
        done_q.push_back(w);
        exp_req_addr = addr & 32'hFFFF_FFF0;
        acc = 0;
        waited = 0;
        @(posedge clk); #1;
        bus.flush_i     = 1'b0;
        bus.miss_addr_i = addr;
        bus.miss_vld_i  = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.miss_rdy_o) break;
            n++;
            if (n > 400) begin timeout_fail("miss_accept"); return; end
        end
        acc = cyc;
        waited = n;
        @(posedge clk); #1;
        bus.miss_vld_i    = 1'b0;
        bus.miss_addr_i   = $urandom;
        bus.mem_req_rdy_i = (stall == 0);
        model_victim = (w + 1) % 4;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.mem_req_vld_o) break;
            n++;
            if (n > 20) begin timeout_fail("mem_req"); return; end
        end
        if (stall > 0) begin
            repeat (stall - 1) begin
                @(posedge clk);
                @(negedge clk);
                chk("req_held", 32'(bus.mem_req_vld_o), 32'd1);
            end
            @(posedge clk); #1;
            bus.mem_req_rdy_i = 1'b1;
            @(negedge clk);
            chk("req_held", 32'(bus.mem_req_vld_o), 32'd1);
        end
        @(posedge clk); #1;
        bus.mem_req_rdy_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == abort) begin
                bus.mem_rsp_vld_i = 1'b1;
                bus.mem_rsp_dat_i = data[i];
                return;
            end
            if (bubble[i]) begin
                bus.mem_rsp_vld_i = 1'b0;
                bus.mem_rsp_dat_i = $urandom;
                @(posedge clk); #1;
            end
            bus.mem_rsp_vld_i = 1'b1;
            bus.mem_rsp_dat_i = data[i];
            @(posedge clk); #1;
        end
        bus.mem_rsp_vld_i = 1'b0;
        bus.mem_rsp_dat_i = '0;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (!bus.busy_o) break;
            n++;
            if (n > 20) begin timeout_fail("refill_end"); return; end
        end
        chk("line_writes_left", 32'(cw_eq.size()), 32'd0);
        chk("tag_writes_left", 32'(tag_eq.size()), 32'd0);
        chk("done_left", 32'(done_q.size()), 32'd0);
    endtask

    initial begin
        int acc;
        int waited;
        int exp3 [5];
        exp3 = '{0, 1, 2, 3, 0};
        bus.miss_vld_i    = 1'b0;
        bus.miss_addr_i   = '0;
        bus.flush_i       = 1'b0;
        bus.mem_req_rdy_i = 1'b0;
        bus.mem_rsp_vld_i = 1'b0;
        bus.mem_rsp_dat_i = '0;

        do_reset(1'b1);

        do_miss(32'h0000_1234, 0, 4'b0000, -1, 32'hA0, acc, waited);
        chk("t2_latency", 32'(done_cyc - acc), 32'd8);
        chk("t2_inval_addr", 32'(last_inval_addr), 32'h23);
        chk("t2_req_addr", seen_req_addr, 32'h0000_1230);
        chk("t2_last_cache_addr", 32'(last_cache_addr), 32'h08F);
        chk("t2_last_cache_wdat", last_cache_wdat, 32'hA3);
        chk("t2_tag_addr", 32'(last_tag_addr), 32'h23);
        chk("t2_tag_wdat", last_tag_wdat, 32'h8000_0002);
        chk("t2_done_way", 32'(done_log[done_log.size() - 1]), 32'd0);

        do_reset(1'b1);
        done_log.delete();
        for (int i = 0; i < 5; i++) do_miss($urandom, 0, 4'b0000, -1, 32'h0, acc, waited);
        chk("t3_done_count", 32'(done_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < done_log.size(); i++) chk("t3_done_way_seq", 32'(done_log[i]), 32'(exp3[i]));

        strobe_cnt = 0;
        do_miss(32'hCAFE_0F44, 5, 4'b1010, -1, 32'h0, acc, waited);
        chk("t4_strobes", 32'(strobe_cnt), 32'd4);

        push_flush();
        @(posedge clk); #1;
        bus.flush_i     = 1'b1;
        bus.miss_vld_i  = 1'b1;
        bus.miss_addr_i = 32'h0007_7770;
        @(negedge clk);
        chk("t5_rdy_masked", 32'(bus.miss_rdy_o), 32'd0);
        do_miss(32'h0007_7770, 1, 4'b0000, -1, 32'h0, acc, waited);
        chk("t5_wait_flush", 32'(waited), 32'd128);

        do_miss(32'h1357_9BD0, 0, 4'b0000, 2, 32'h0, acc, waited);
        do_reset(1'b0);
        done_log.delete();
        do_miss(32'h2468_ACE8, 0, 4'b0000, -1, 32'h0, acc, waited);
        chk("t6_way_after_reset", 32'(done_log[0]), 32'd0);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 4) == 0) do_flush();
            else do_miss($urandom, int'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), -1, 32'h0, acc, waited);
        end

        chk("final_tag_left", 32'(tag_eq.size()), 32'd0);
        chk("final_line_left", 32'(cw_eq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
